// File: rtl/gate_sweep_pkg.sv
// Shared constants and FSM state type for the LogicGates sweep controller.
package gate_sweep_pkg;

    localparam logic [1:0] SEL_NOT = 2'b00;
    localparam logic [1:0] SEL_AND = 2'b01;
    localparam logic [1:0] SEL_OR  = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    localparam int NUM_VECTORS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SAMPLE = 2'b10,
        DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Operand/select bus between the sweep controller and the LogicGates instance under test.
interface gate_sweep_ctrl_if;
    logic [1:0] sel;
    logic       A;
    logic       B;
    logic       Y;

    modport master (output sel, output A, output B, input Y);
    modport slave  (input sel, input A, input B, output Y);
endinterface

// File: rtl/gate_sweep_ctrl_ref_model.sv
// Combinational golden model of the LogicGates function used to grade each vector.
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       A,
    input  logic       B,
    output logic       exp_Y
);

    always_comb begin
        exp_Y = 1'b0;
        case (sel)
            SEL_NOT: exp_Y = ~A;
            SEL_AND: exp_Y = A & B;
            SEL_OR:  exp_Y = A | B;
            SEL_XOR: exp_Y = A ^ B;
            default: exp_Y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a LogicGates instance with settle time and error counting.
// Optional first-failure capture ports are enabled by defining GATE_SWEEP_FIRST_FAIL_EN.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    gate_sweep_ctrl_if.master gate,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_count,
    output logic [3:0]        vec_idx
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ,
    output logic              first_fail_vld,
    output logic [3:0]        first_fail_idx
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [3:0] vec_idx_q, vec_idx_d;
    logic [4:0] err_count_q, err_count_d;
    logic [3:0] settle_q, settle_d;
    logic       exp_y;
    logic       mismatch;

    gate_ref_model u_ref (
        .sel   (vec_idx_q[3:2]),
        .A     (vec_idx_q[1]),
        .B     (vec_idx_q[0]),
        .exp_Y (exp_y)
    );

    assign mismatch = (gate.Y != exp_y);

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic       ff_vld_q, ff_vld_d;
    logic [3:0] ff_idx_q, ff_idx_d;
`endif

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        err_count_d = err_count_q;
        settle_d    = settle_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        ff_vld_d    = ff_vld_q;
        ff_idx_d    = ff_idx_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_idx_d   = '0;
                    err_count_d = '0;
                    settle_d    = SETTLE_LOAD;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                    ff_vld_d    = 1'b0;
                    ff_idx_d    = '0;
`endif
                end
            end
            DRIVE: begin
                // Down-counter: terminal count ends the settle window.
                if (settle_q == '0) state_d = SAMPLE;
                else                settle_d = settle_q - 4'd1;
            end
            SAMPLE: begin
                if (mismatch && (err_count_q != 5'd31)) err_count_d = err_count_q + 5'd1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                if (mismatch && !ff_vld_q) begin
                    ff_vld_d = 1'b1;
                    ff_idx_d = vec_idx_q;
                end
`endif
                if (vec_idx_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d   = DRIVE;
                    vec_idx_d = vec_idx_q + 4'd1;
                    settle_d  = SETTLE_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_idx_q   <= '0;
            err_count_q <= '0;
            settle_q    <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_vld_q    <= 1'b0;
            ff_idx_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            err_count_q <= err_count_d;
            settle_q    <= settle_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            ff_vld_q    <= ff_vld_d;
            ff_idx_q    <= ff_idx_d;
`endif
        end
    end

    // vec_idx is held at zero in IDLE, so the gate bus idles at 00/0/0.
    assign gate.sel  = vec_idx_q[3:2];
    assign gate.A    = vec_idx_q[1];
    assign gate.B    = vec_idx_q[0];
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_count_q == '0);
    assign err_count = err_count_q;
    assign vec_idx   = vec_idx_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: emulated LogicGates with fault injection
// and a cycle-count reference of the sweep schedule.
module tb_gate_sweep_ctrl;

    localparam int SETTLE  = 2;
    localparam int PER_VEC = SETTLE + 1;
    localparam int SWEEP   = 16 * PER_VEC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] vec_idx;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic       first_fail_vld;
    logic [3:0] first_fail_idx;
`endif

    logic [15:0] fault_mask = '0;
    logic        tie0 = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    gate_sweep_ctrl_if gif ();

    gate_sweep_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .gate           (gif.master),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .vec_idx        (vec_idx)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        ,
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
`endif
    );

    always #5 clk = ~clk;

    // Truth of the gate for vector v: sel = v[3:2], A = v[1], B = v[0].
    function automatic logic gate_fn(input logic [3:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        case (v[3:2])
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic fault_at(input logic [3:0] v);
        return tie0 ? gate_fn(v) : fault_mask[v];
    endfunction

    assign gif.Y = tie0 ? 1'b0
                        : (gate_fn({gif.sel, gif.A, gif.B}) ^ fault_mask[{gif.sel, gif.A, gif.B}]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"},  busy,      0);
        chk({tag, " done"},  done,      0);
        chk({tag, " pass"},  pass,      0);
        chk({tag, " err"},   err_count, 0);
        chk({tag, " vec"},   vec_idx,   0);
        chk({tag, " sel"},   gif.sel,   0);
        chk({tag, " A"},     gif.A,     0);
        chk({tag, " B"},     gif.B,     0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk({tag, " ffvld"}, first_fail_vld, 0);
        chk({tag, " ffidx"}, first_fail_idx, 0);
`endif
    endtask

    // One sweep; k counts cycles from the first DRIVE cycle, sampled at negedge.
    task automatic run_sweep(input logic [15:0] m, input logic t0,
                             input bit inj_start, input bit do_rst);
        int         exp_err, total, first_idx;
        logic [3:0] vv;
        fault_mask = m;
        tie0       = t0;
        total      = 0;
        first_idx  = -1;
        for (int j = 0; j < 16; j++) begin
            if (fault_at(4'(j))) begin
                total++;
                if (first_idx < 0) first_idx = j;
            end
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k <= SWEEP; k++) begin
            if (k < SWEEP) begin
                vv = 4'(k / PER_VEC);
                exp_err = 0;
                for (int j = 0; j < 16; j++)
                    if (j < int'(vv) && fault_at(4'(j))) exp_err++;
                chk("run busy", busy,      1);
                chk("run done", done,      0);
                chk("run pass", pass,      0);
                chk("run vec",  vec_idx,   vv);
                chk("run err",  err_count, exp_err);
                chk("run sel",  gif.sel,   vv[3:2]);
                chk("run A",    gif.A,     vv[1]);
                chk("run B",    gif.B,     vv[0]);
            end else begin
                chk("end busy", busy,      0);
                chk("end done", done,      1);
                chk("end err",  err_count, total);
                chk("end pass", pass,      total == 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                chk("end ffvld", first_fail_vld, total != 0);
                if (total != 0) chk("end ffidx", first_fail_idx, first_idx);
`endif
            end
            if (do_rst && k == 9 * PER_VEC) begin
                rst   = 1'b1;
                start = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                check_idle("abort");
                @(negedge clk);
                check_idle("abort hold");
                return;
            end
            start = inj_start && (k == 5 * PER_VEC + 1);
            if (k < SWEEP) @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post reset");

        run_sweep(16'h0000, 1'b0, 1'b0, 1'b0);
        run_sweep(16'h0000, 1'b1, 1'b0, 1'b0);
        run_sweep(16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_sweep(16'h0000, 1'b0, 1'b1, 1'b0);
        run_sweep(16'h0000, 1'b0, 1'b0, 1'b1);
        run_sweep(16'h0000, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (r[0]) m = m & 16'($urandom);
            run_sweep(m, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
        end
        run_sweep(16'h8001, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
